// File: rtl/fetch_stage_unit_pkg.sv
// Shared definitions for the fetch stage: hold-buffer FSM encoding, NOP word, PC step
// and the saturating increment used by the optional performance counters.
package fetch_stage_unit_pkg;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HOLD = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned PC_STEP   = 4;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      logic [31:0] result;
      if (value == 32'hFFFF_FFFF) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_stage_unit_if.sv
// Fetch stage bus: hazard controls in, instruction ROM port, IF/ID outputs to decode.
// master = the fetch stage itself, slave = the surrounding pipeline/ROM.
interface fetch_stage_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              pc_write_i;
   logic              fd_write_i;
   logic              if_id_flush_i;
   logic              branch_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_rdata_i;
   logic [ADDR_W-1:0] fd_pc4_o;
   logic [31:0]       fd_instr_o;
   logic              fd_valid_o;

   modport master (
      input  pc_write_i,
      input  fd_write_i,
      input  if_id_flush_i,
      input  branch_i,
      input  branch_target_i,
      input  imem_rdata_i,
      output imem_addr_o,
      output fd_pc4_o,
      output fd_instr_o,
      output fd_valid_o
   );

   modport slave (
      output pc_write_i,
      output fd_write_i,
      output if_id_flush_i,
      output branch_i,
      output branch_target_i,
      output imem_rdata_i,
      input  imem_addr_o,
      input  fd_pc4_o,
      input  fd_instr_o,
      input  fd_valid_o
   );

endinterface

// File: rtl/fetch_hold_buffer.sv
// Parks the ROM response that arrives while decode is stalled and replays it on release;
// selects the IF/ID source between the live ROM response and the parked copy.
module fetch_hold_buffer
   import fetch_stage_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fd_write,
   input  logic              if_id_flush,
   input  logic              resp_valid,
   input  logic [ADDR_W-1:0] resp_pc,
   input  logic [31:0]       rdata,
   output logic [31:0]       src_instr,
   output logic [ADDR_W-1:0] src_pc,
   output logic              src_valid
);

   fetch_state_e      state_r;
   fetch_state_e      state_next_s;
   logic              capture_s;
   logic [31:0]       hold_instr_r;
   logic [ADDR_W-1:0] hold_pc_r;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r <= S_RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; capture only when a valid response would otherwise be lost
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      case (state_r)
         S_RUN: begin
            if (!fd_write && !if_id_flush && resp_valid) begin
               state_next_s = S_HOLD;
               capture_s    = 1'b1;
            end else begin
               state_next_s = S_RUN;
            end
         end
         S_HOLD: begin
            if (fd_write || if_id_flush) begin
               state_next_s = S_RUN;
            end else begin
               state_next_s = S_HOLD;
            end
         end
         default: begin
            state_next_s = S_RUN;
         end
      endcase
   end

   // Hold buffer storage
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         hold_instr_r <= NOP_INSTR;
         hold_pc_r    <= {ADDR_W{1'b0}};
      end else if (if_id_flush) begin
         hold_instr_r <= NOP_INSTR;
         hold_pc_r    <= {ADDR_W{1'b0}};
      end else if (capture_s) begin
         hold_instr_r <= rdata;
         hold_pc_r    <= resp_pc;
      end else begin
         hold_instr_r <= hold_instr_r;
         hold_pc_r    <= hold_pc_r;
      end
   end

   // IF/ID source select
   always_comb begin
      src_instr = rdata;
      src_pc    = resp_pc;
      src_valid = resp_valid;
      case (state_r)
         S_HOLD: begin
            src_instr = hold_instr_r;
            src_pc    = hold_pc_r;
            src_valid = 1'b1;
         end
         S_RUN: begin
            src_instr = rdata;
            src_pc    = resp_pc;
            src_valid = resp_valid;
         end
         default: begin
            src_instr = rdata;
            src_pc    = resp_pc;
            src_valid = resp_valid;
         end
      endcase
   end

endmodule

// File: rtl/fetch_stage_unit.sv
// Fetch stage with IF/ID register: owns the PC, drives a 1-cycle-latency ROM and feeds decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush cycle counters.
module fetch_stage_unit
   import fetch_stage_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        stall_cnt_o,
   output logic [31:0]        flush_cnt_o,
`endif
   fetch_stage_unit_if.master bus
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_next_s;
   logic              resp_v_r;
   logic [ADDR_W-1:0] resp_pc_r;
   logic [ADDR_W-1:0] fd_pc4_r;
   logic [31:0]       fd_instr_r;
   logic              fd_valid_r;
   logic [31:0]       src_instr_s;
   logic [ADDR_W-1:0] src_pc_s;
   logic              src_valid_s;

   // Next PC: redirect or sequential step, wrapping modulo 2^ADDR_W
   always_comb begin
      if (bus.branch_i) begin
         pc_next_s = bus.branch_target_i;
      end else begin
         pc_next_s = pc_r + STEP;
      end
   end

   // PC and in-flight response tracking; a branch or flush kills the fetch issued now
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_r      <= RESET_PC;
         resp_v_r  <= 1'b0;
         resp_pc_r <= {ADDR_W{1'b0}};
      end else begin
         resp_v_r  <= bus.pc_write_i & ~bus.branch_i & ~bus.if_id_flush_i;
         resp_pc_r <= pc_r;
         if (bus.pc_write_i) begin
            pc_r <= pc_next_s;
         end else begin
            pc_r <= pc_r;
         end
      end
   end

   fetch_hold_buffer #(
      .ADDR_W (ADDR_W)
   ) u_hold (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .fd_write    (bus.fd_write_i),
      .if_id_flush (bus.if_id_flush_i),
      .resp_valid  (resp_v_r),
      .resp_pc     (resp_pc_r),
      .rdata       (bus.imem_rdata_i),
      .src_instr   (src_instr_s),
      .src_pc      (src_pc_s),
      .src_valid   (src_valid_s)
   );

   // IF/ID pipeline register: flush beats write beats hold
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fd_pc4_r   <= {ADDR_W{1'b0}};
         fd_instr_r <= NOP_INSTR;
         fd_valid_r <= 1'b0;
      end else if (bus.if_id_flush_i) begin
         fd_pc4_r   <= {ADDR_W{1'b0}};
         fd_instr_r <= NOP_INSTR;
         fd_valid_r <= 1'b0;
      end else if (bus.fd_write_i) begin
         fd_pc4_r   <= src_pc_s + STEP;
         fd_instr_r <= src_valid_s ? src_instr_s : NOP_INSTR;
         fd_valid_r <= src_valid_s;
      end else begin
         fd_pc4_r   <= fd_pc4_r;
         fd_instr_r <= fd_instr_r;
         fd_valid_r <= fd_valid_r;
      end
   end

   assign bus.imem_addr_o = pc_r;
   assign bus.fd_pc4_o    = fd_pc4_r;
   assign bus.fd_instr_o  = fd_instr_r;
   assign bus.fd_valid_o  = fd_valid_r;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating stall and flush cycle counters
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_r <= 32'h0000_0000;
         flush_cnt_r <= 32'h0000_0000;
      end else begin
         if (!bus.fd_write_i && !bus.if_id_flush_i) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (bus.if_id_flush_i) begin
            flush_cnt_r <= sat_inc32(flush_cnt_r);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Self-checking bench for fetch_stage_unit: instruction-stream model (queue of issued PCs)
// compared every cycle, plus hand-computed literal pins and randomized legal hazard controls.
module tb_fetch_stage_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_unit_if #(.ADDR_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   fetch_stage_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
`ifdef FETCH_PERF_CNT_EN
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt),
`endif
      .bus         (bus)
   );

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h0000_0100;
   endfunction

   // ROM with one cycle of read latency
   always @(posedge clk) bus.imem_rdata_i <= rom_f(bus.imem_addr_o);

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: PC, queue of fetched-but-undelivered PCs, expected IF/ID, perf counts
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_pend[$];
   logic        m_v  = 1'b0;
   logic [31:0] m_i  = 32'h0;
   logic [31:0] m_p4 = 32'h0;
   logic [31:0] m_stall = 32'h0;
   logic [31:0] m_flush = 32'h0;

   logic c_pw, c_fw, c_fl, c_br;
   logic [31:0] c_tgt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_update();
      if (!rst) begin
         m_pc = 32'h0; m_pend.delete();
         m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
         m_stall = 32'h0; m_flush = 32'h0;
         return;
      end
      if (!c_fw && !c_fl) m_stall = sat(m_stall);
      if (c_fl) m_flush = sat(m_flush);
      if (c_fl) begin
         m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
         m_pend.delete();
      end else if (c_fw) begin
         if (m_pend.size() > 0) begin
            logic [31:0] p;
            p = m_pend.pop_front();
            m_v = 1'b1; m_i = rom_f(p); m_p4 = p + 32'd4;
         end else begin
            m_v = 1'b0; m_i = 32'h0;
         end
      end
      if (c_pw) begin
         if (!c_br && !c_fl) m_pend.push_back(m_pc);
         m_pc = c_br ? c_tgt : m_pc + 32'd4;
      end
   endtask

   task automatic step(input logic r, input logic pw, input logic fw, input logic fl,
                       input logic br, input logic [31:0] tgt);
      if (r && pw && !fw && !fl) begin
         bad++;
         $display("FAIL illegal_ctrl: pc_write=1 fd_write=0 flush=0 generated at %0t", $time);
      end
      rst = r; c_pw = pw; c_fw = fw; c_fl = fl; c_br = br; c_tgt = tgt;
      bus.pc_write_i = pw; bus.fd_write_i = fw; bus.if_id_flush_i = fl;
      bus.branch_i = br; bus.branch_target_i = tgt;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic run();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic stall();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("fd_valid", {31'd0, bus.fd_valid_o}, {31'd0, m_v});
         chk("fd_instr", bus.fd_instr_o, m_i);
         if (m_v) chk("fd_pc4", bus.fd_pc4_o, m_p4);
         chk("imem_addr", bus.imem_addr_o, m_pc);
`ifdef FETCH_PERF_CNT_EN
         chk("stall_cnt", stall_cnt, m_stall);
         chk("flush_cnt", flush_cnt, m_flush);
`endif
      end
   end

   initial begin
      int op;
      logic [31:0] t;
      bus.pc_write_i = 1'b0; bus.fd_write_i = 1'b0; bus.if_id_flush_i = 1'b0;
      bus.branch_i = 1'b0; bus.branch_target_i = 32'h0;
      c_pw = 1'b0; c_fw = 1'b0; c_fl = 1'b0; c_br = 1'b0; c_tgt = 32'h0;

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_en = 1'b1;
      chk("rst_valid", {31'd0, bus.fd_valid_o}, 32'h0);
      chk("rst_instr", bus.fd_instr_o, 32'h0);
      chk("rst_pc4", bus.fd_pc4_o, 32'h0);
      chk("rst_addr", bus.imem_addr_o, 32'h0);

      // Free run: first valid on the second edge
      run();
      chk("run1_valid", {31'd0, bus.fd_valid_o}, 32'h0);
      run(); chk("run2_instr", bus.fd_instr_o, 32'h100); chk("run2_pc4", bus.fd_pc4_o, 32'h4);
      run(); chk("run3_instr", bus.fd_instr_o, 32'h101); chk("run3_pc4", bus.fd_pc4_o, 32'h8);
      run(); chk("run4_instr", bus.fd_instr_o, 32'h102); chk("run4_pc4", bus.fd_pc4_o, 32'hC);

      // One-cycle load-use stall
      stall();
      chk("st1_hold", bus.fd_instr_o, 32'h102); chk("st1_addr", bus.imem_addr_o, 32'h10);
      run(); chk("st1_next", bus.fd_instr_o, 32'h103); chk("st1_next_pc4", bus.fd_pc4_o, 32'h10);
      run(); chk("st1_next2", bus.fd_instr_o, 32'h104);

      // Three-cycle stall
      for (int i = 0; i < 3; i++) begin
         stall();
         chk("st3_addr", bus.imem_addr_o, 32'h18);
         chk("st3_hold", bus.fd_instr_o, 32'h104);
      end
      run(); chk("st3_rel", bus.fd_instr_o, 32'h105); chk("st3_rel_pc4", bus.fd_pc4_o, 32'h18);
      run(); chk("st3_rel2", bus.fd_instr_o, 32'h106); chk("br_pc", bus.imem_addr_o, 32'h20);

      // Branch redirect 0x20 -> 0x80
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
      chk("br_valid", {31'd0, bus.fd_valid_o}, 32'h0); chk("br_instr", bus.fd_instr_o, 32'h0);
      run(); chk("br_bubble", {31'd0, bus.fd_valid_o}, 32'h0);
      run(); chk("br_tgt_pc4", bus.fd_pc4_o, 32'h84); chk("br_tgt_instr", bus.fd_instr_o, 32'h120);

      // Flush while holding
      stall();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("hflush_valid", {31'd0, bus.fd_valid_o}, 32'h0);
      run(); chk("hflush_dropped", {31'd0, bus.fd_valid_o}, 32'h0);
      run(); chk("hflush_next", bus.fd_instr_o, 32'h122); chk("hflush_pc4", bus.fd_pc4_o, 32'h8C);

      // Reset in the middle of a stall
      run(); stall();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("mrst_valid", {31'd0, bus.fd_valid_o}, 32'h0);
      chk("mrst_addr", bus.imem_addr_o, 32'h0);
      run(); chk("mrst_bubble", {31'd0, bus.fd_valid_o}, 32'h0);
      run(); chk("mrst_instr", bus.fd_instr_o, 32'h100); chk("mrst_pc4", bus.fd_pc4_o, 32'h4);

      // PC wrap
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      run(); run();
      chk("wrap_instr", bus.fd_instr_o, 32'h4000_00FF);
      chk("wrap_pc4", bus.fd_pc4_o, 32'h0);
      chk("wrap_addr", bus.imem_addr_o, 32'h4);

      // Randomized legal control sequences
      for (int n = 0; n < 3000; n++) begin
         op = $urandom_range(0, 99);
         t  = $urandom;
         t  = {t[31:2], 2'b00};
         if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
         if (op < 55)      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t);
         else if (op < 70) step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), t);
         else if (op < 78) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, t);
         else if (op < 83) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, t);
         else if (op < 88) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, t);
         else if (op < 93) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t);
         else if (op < 99) step(1'b1, 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), t);
         else              step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
